// File: rtl/sync_uart_rx_pkg.sv
// Shared types and widths for the sync-word UART receiver.
// Optional even parity is enabled by defining SYNC_UART_RX_PARITY_EN.
package sync_uart_rx_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/sync_uart_rx_byte.sv
// Single-byte UART receiver: synchronizer, start/data/stop sampling.
// Defining SYNC_UART_RX_PARITY_EN adds an even-parity bit after bit 7.
module uart_rx_byte
  import sync_uart_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              uart,
  output logic [BYTE_W-1:0] byte_data,
  output logic              byte_valid,
  output logic              byte_err
);

`ifdef SYNC_UART_RX_PARITY_EN
  localparam int unsigned FRAME_BITS = BYTE_W + 1;
`else
  localparam int unsigned FRAME_BITS = BYTE_W;
`endif

  localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       LAST_BIT = 4'(FRAME_BITS - 1);

  logic                  meta;
  logic                  line;
  logic                  line_q;
  logic                  armed;
  rx_state_t             state;
  logic [CNT_W-1:0]      cnt;
  logic [3:0]            bit_idx;
  logic [FRAME_BITS-1:0] shreg;
  logic                  frame_ok;

  always_comb begin
    frame_ok = line;
`ifdef SYNC_UART_RX_PARITY_EN
    // Even parity: data plus parity bit must hold an even number of ones.
    frame_ok = line && !(^shreg);
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta       <= 1'b1;
      line       <= 1'b1;
      line_q     <= 1'b1;
      armed      <= 1'b0;
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
    end else begin
      meta       <= uart;
      line       <= meta;
      line_q     <= line;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
      case (state)
        IDLE: begin
          bit_idx <= '0;
          // After reset the line must sit high for a bit period before a
          // falling edge is trusted, so a mid-frame reset cannot start on a data 0.
          if (!armed) begin
            if (!line) begin
              cnt <= '0;
            end else if (cnt == LAST) begin
              cnt   <= '0;
              armed <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            cnt <= '0;
            if (line_q && !line) state <= START;
          end
        end
        START: begin
          if (cnt == HALF) begin
            cnt   <= '0;
            state <= line ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            shreg <= {line, shreg[FRAME_BITS-1:1]};
            if (bit_idx == LAST_BIT) state <= STOP;
            else                     bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= IDLE;
            if (frame_ok) begin
              byte_valid <= 1'b1;
              byte_data  <= shreg[BYTE_W-1:0];
            end else begin
              byte_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sync_uart_rx.sv
// Sync-word receiver: assembles N_BYTES UART bytes little-endian after sync_pulse.
// Byte framing (8N1, or 8E1 with SYNC_UART_RX_PARITY_EN) lives in uart_rx_byte.
module sync_uart_rx
  import sync_uart_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned N_BYTES      = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              sync_pulse,
  input  logic              uart,
  output logic [WORD_W-1:0] sync_num,
  output logic              sync_valid,
  output logic              frame_err
);

  localparam logic [1:0] LAST_IDX = 2'(N_BYTES - 1);

  logic [BYTE_W-1:0] byte_data;
  logic              byte_valid;
  logic              byte_err;
  logic [1:0]        byte_idx;
  logic [WORD_W-1:0] partial;
  logic [WORD_W-1:0] word_next;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CNT_W       (CNT_W)
  ) u_byte (
    .clk       (clk),
    .rstn      (rstn),
    .uart      (uart),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .byte_err  (byte_err)
  );

  always_comb begin
    word_next = partial | (WORD_W'(byte_data) << {byte_idx, 3'b000});
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      byte_idx   <= '0;
      partial    <= '0;
      sync_num   <= '0;
      sync_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sync_valid <= 1'b0;
      frame_err  <= byte_err;
      // sync_pulse wins over a coincident byte, dropping it.
      if (sync_pulse || byte_err) begin
        byte_idx <= '0;
        partial  <= '0;
      end else if (byte_valid) begin
        if (byte_idx == LAST_IDX) begin
          sync_num   <= word_next;
          sync_valid <= 1'b1;
          byte_idx   <= '0;
          partial    <= '0;
        end else begin
          partial  <= word_next;
          byte_idx <= byte_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sync_uart_rx.sv
// Self-checking bench for sync_uart_rx (CLKS_PER_BIT=8, N_BYTES=4).
// Parity cases run only when SYNC_UART_RX_PARITY_EN is defined.
module tb_sync_uart_rx;
  import sync_uart_rx_pkg::*;

  localparam int unsigned CPB = 8;
  localparam int unsigned NB  = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        sync_pulse;
  logic        uart;
  logic [31:0] sync_num;
  logic        sync_valid;
  logic        frame_err;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned n_valid = 0;
  int unsigned n_err = 0;
  logic [31:0] exp_words[$];
  logic        prev_valid = 1'b0;
  logic        prev_err = 1'b0;

  sync_uart_rx #(
    .CLKS_PER_BIT(CPB),
    .N_BYTES     (NB),
    .CNT_W       (16)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .sync_pulse(sync_pulse),
    .uart      (uart),
    .sync_num  (sync_num),
    .sync_valid(sync_valid),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Every sync_valid is matched against the next expected word.
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (sync_valid) begin
        n_valid++;
        if (exp_words.size() == 0) check("unexpected_sync_valid", sync_num, 32'hFFFF_FFFF ^ sync_num);
        else check("sync_word", sync_num, exp_words.pop_front());
        if (prev_valid) check("sync_valid_width", 32'd2, 32'd1);
      end
      if (frame_err) begin
        n_err++;
        if (prev_err) check("frame_err_width", 32'd2, 32'd1);
      end
      prev_valid = sync_valid;
      prev_err   = frame_err;
    end else begin
      prev_valid = 1'b0;
      prev_err   = 1'b0;
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_sync();
    sync_pulse = 1'b1;
    tick(1);
    sync_pulse = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    uart = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart = d[i];
      tick(CPB);
    end
`ifdef SYNC_UART_RX_PARITY_EN
    uart = ^d;
    tick(CPB);
`endif
    uart = stop;
    tick(CPB);
    uart = 1'b1;
    tick(2 * CPB);
  endtask

`ifdef SYNC_UART_RX_PARITY_EN
  task automatic send_byte_par(input logic [7:0] d, input logic par);
    uart = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart = d[i];
      tick(CPB);
    end
    uart = par;
    tick(CPB);
    uart = 1'b1;
    tick(CPB);
    tick(2 * CPB);
  endtask
`endif

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned v0, e0;
    logic [7:0]  q[$];
    int unsigned model_err;

    vecs[0] = '{8'h78, 8'h56, 8'h34, 8'h12, 32'h12345678};
    vecs[1] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 32'hDEADBEEF};
    vecs[2] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 32'hFF00FF00};
    vecs[3] = '{8'hA5, 8'h5A, 8'hC3, 8'h3C, 32'h3CC35AA5};

    rstn = 1'b0;
    uart = 1'b1;
    sync_pulse = 1'b0;
    tick(3);
    check("reset_sync_num", sync_num, 32'h0);
    check("reset_sync_valid", 32'(sync_valid), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    rstn = 1'b1;
    tick(3 * CPB);

    // Table-driven words, each preceded by a sync pulse.
    for (int i = 0; i < 4; i++) begin
      v0 = n_valid;
      exp_words.push_back(vecs[i].exp);
      pulse_sync();
      send_byte(vecs[i].b0, 1'b1);
      send_byte(vecs[i].b1, 1'b1);
      send_byte(vecs[i].b2, 1'b1);
      send_byte(vecs[i].b3, 1'b1);
      check("table_valid_count", n_valid - v0, 32'd1);
      check("table_word", sync_num, vecs[i].exp);
    end

    // Bad stop bit, then a fresh word with no sync pulse.
    e0 = n_err;
    v0 = n_valid;
    send_byte(8'h55, 1'b0);
    check("bad_stop_err", n_err - e0, 32'd1);
    exp_words.push_back(32'h00000001);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    check("after_err_valid", n_valid - v0, 32'd1);
    check("after_err_word", sync_num, 32'h00000001);

    // Short low glitch on an idle line.
    e0 = n_err;
    v0 = n_valid;
    uart = 1'b0;
    tick(2);
    uart = 1'b1;
    tick(4 * CPB);
    check("glitch_err", n_err - e0, 32'd0);
    check("glitch_valid", n_valid - v0, 32'd0);
    check("glitch_state_idle", 32'(dut.u_byte.state), 32'(IDLE));

    // Stale bytes discarded by a sync pulse.
    v0 = n_valid;
    exp_words.push_back(32'hDEADBEEF);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    pulse_sync();
    send_byte(8'hEF, 1'b1);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hAD, 1'b1);
    send_byte(8'hDE, 1'b1);
    check("resync_valid", n_valid - v0, 32'd1);
    check("resync_word", sync_num, 32'hDEADBEEF);

    // sync_pulse coinciding with the 4th byte's completion drops it.
    v0 = n_valid;
    pulse_sync();
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    fork
      send_byte(8'h04, 1'b1);
      begin : hit
        int unsigned n;
        n = 0;
        while (dut.u_byte.byte_valid !== 1'b1 && n < 40 * CPB) begin
          @(negedge clk);
          n++;
        end
        check("coincide_seen", 32'(n < 40 * CPB), 32'd1);
        sync_pulse = 1'b1;
        @(negedge clk);
        sync_pulse = 1'b0;
      end
    join
    check("coincide_no_valid", n_valid - v0, 32'd0);
    exp_words.push_back(32'h44332211);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    check("coincide_next_word", sync_num, 32'h44332211);

    // Reset during bit 4 of byte 2.
    v0 = n_valid;
    pulse_sync();
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    uart = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) tick(CPB);
    tick(CPB / 2);
    rstn = 1'b0;
    #1;
    check("midreset_sync_num", sync_num, 32'h0);
    check("midreset_valid", 32'(sync_valid), 32'd0);
    check("midreset_err", 32'(frame_err), 32'd0);
    tick(3);
    rstn = 1'b1;
    e0 = n_err;
    tick(CPB / 2 + 3 * CPB - 3);
    uart = 1'b1;
    tick(CPB);
    tick(3 * CPB);
    check("midreset_no_err", n_err - e0, 32'd0);
    check("midreset_no_valid", n_valid - v0, 32'd0);
    exp_words.push_back(32'hCAFEF00D);
    pulse_sync();
    send_byte(8'h0D, 1'b1);
    send_byte(8'hF0, 1'b1);
    send_byte(8'hFE, 1'b1);
    send_byte(8'hCA, 1'b1);
    check("postreset_word", sync_num, 32'hCAFEF00D);

`ifdef SYNC_UART_RX_PARITY_EN
    e0 = n_err;
    v0 = n_valid;
    pulse_sync();
    send_byte_par(8'h03, 1'b1);
    check("parity_bad_err", n_err - e0, 32'd1);
    exp_words.push_back(32'h00000003);
    send_byte_par(8'h03, 1'b0);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    check("parity_good_word", sync_num, 32'h00000003);
    check("parity_valid", n_valid - v0, 32'd1);
`endif

    // Randomized traffic against a byte-list model.
    pulse_sync();
    q.delete();
    model_err = 0;
    e0 = n_err;
    for (int op = 0; op < 40; op++) begin
      int unsigned r;
      logic [7:0]  d;
      r = $urandom_range(0, 9);
      d = 8'($urandom);
      if (r < 2) begin
        pulse_sync();
        q.delete();
      end else if (r == 2) begin
        send_byte(d, 1'b0);
        model_err++;
        q.delete();
      end else begin
        logic [31:0] w;
        q.push_back(d);
        if (q.size() == NB) begin
          w = '0;
          for (int k = 0; k < int'(NB); k++) w = w + (32'(q[k]) << (8 * k));
          exp_words.push_back(w);
          q.delete();
        end
        send_byte(d, 1'b1);
      end
    end
    check("random_err_count", n_err - e0, model_err);
    check("all_words_seen", exp_words.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
